// File: rtl/program_sequencer.sv
// Instruction sequencer: steps pc through a synchronous instruction memory and
// issues each fetched 11-bit word over a valid/ready handshake, with run/step/halt control.
module program_sequencer #(
    parameter int unsigned PC_W = 4
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            start,
    input  logic            step,
    input  logic            halt_req,
    input  logic [PC_W-1:0] prog_len,
    output logic [PC_W-1:0] imem_addr,
    output logic            imem_rd,
    input  logic [10:0]     imem_data,
    output logic            issue_valid,
    input  logic            issue_ready,
    output logic [2:0]      opcode,
    output logic [3:0]      mem_addr,
    output logic [3:0]      imm_val,
    output logic [PC_W-1:0] pc,
    output logic            busy,
    output logic            done
);

    localparam int unsigned INSN_W = 11;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_ISSUE = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    typedef enum logic {
        M_RUN  = 1'b0,
        M_STEP = 1'b1
    } mode_t;

    state_t              state, state_nxt;
    mode_t               mode, mode_nxt;
    logic [PC_W-1:0]     pc_nxt;
    logic                halt_pend, halt_pend_nxt;
    logic [INSN_W-1:0]   ir;

    // Next-state, pc and control-flag logic
    always_comb begin
        state_nxt     = state;
        pc_nxt        = pc;
        halt_pend_nxt = halt_pend;
        mode_nxt      = mode;
        unique case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    pc_nxt        = '0;
                    halt_pend_nxt = 1'b0;
                    mode_nxt      = M_RUN;
                    state_nxt     = S_REQ;
                end else if (step && (state == S_IDLE)) begin
                    mode_nxt  = M_STEP;
                    state_nxt = S_REQ;
                end
            end
            S_REQ: begin
                if (halt_req) halt_pend_nxt = 1'b1;
                state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (halt_req) halt_pend_nxt = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                if (halt_req) halt_pend_nxt = 1'b1;
                if (issue_ready) begin
                    if (pc == prog_len) begin
                        state_nxt = S_DONE;
                    end else begin
                        pc_nxt = pc + PC_W'(1);
                        if ((mode == M_RUN) && !halt_pend) begin
                            state_nxt = S_REQ;
                        end else begin
                            state_nxt     = S_IDLE;
                            halt_pend_nxt = 1'b0;
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, instruction register and registered status outputs
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state       <= S_IDLE;
            mode        <= M_RUN;
            pc          <= '0;
            halt_pend   <= 1'b0;
            ir          <= '0;
            imem_rd     <= 1'b0;
            issue_valid <= 1'b0;
            busy        <= 1'b0;
            done        <= 1'b0;
        end else begin
            state       <= state_nxt;
            mode        <= mode_nxt;
            pc          <= pc_nxt;
            halt_pend   <= halt_pend_nxt;
            if (state == S_WAIT) ir <= imem_data;
            imem_rd     <= (state_nxt == S_REQ);
            issue_valid <= (state_nxt == S_ISSUE);
            busy        <= (state_nxt == S_REQ) || (state_nxt == S_WAIT) || (state_nxt == S_ISSUE);
            done        <= (state_nxt == S_DONE);
        end
    end

    assign imem_addr = pc;
    assign opcode    = ir[10:8];
    assign mem_addr  = ir[7:4];
    assign imm_val   = ir[3:0];

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer: run, backpressure, step, halt,
// boundary and asynchronous-reset scenarios against hand-computed values.
module tb_program_sequencer;

    localparam int unsigned PC_W = 4;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            start = 1'b0;
    logic            step = 1'b0;
    logic            halt_req = 1'b0;
    logic [PC_W-1:0] prog_len = 4'd3;
    logic [PC_W-1:0] imem_addr;
    logic            imem_rd;
    logic [10:0]     imem_data = 11'h0;
    logic            issue_valid;
    logic            issue_ready = 1'b1;
    logic [2:0]      opcode;
    logic [3:0]      mem_addr;
    logic [3:0]      imm_val;
    logic [PC_W-1:0] pc;
    logic            busy;
    logic            done;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int t0;
    logic [10:0] mem [16];
    logic [10:0] log_q [$];
    int          tlog_q [$];
    logic [10:0] exp_prog [4];

    program_sequencer #(.PC_W(PC_W)) dut (
        .clk(clk), .rstn(rstn), .start(start), .step(step), .halt_req(halt_req),
        .prog_len(prog_len), .imem_addr(imem_addr), .imem_rd(imem_rd),
        .imem_data(imem_data), .issue_valid(issue_valid), .issue_ready(issue_ready),
        .opcode(opcode), .mem_addr(mem_addr), .imm_val(imm_val), .pc(pc),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    // Synchronous instruction memory: data valid the cycle after imem_rd
    always @(posedge clk) if (imem_rd) imem_data <= mem[imem_addr];

    // Transfer log with edge index
    always @(posedge clk) begin
        if (rstn && issue_valid && issue_ready) begin
            log_q.push_back({opcode, mem_addr, imm_val});
            tlog_q.push_back(cyc);
        end
        cyc++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic load_prog();
        for (int i = 0; i < 16; i++) mem[i] = 11'h0;
        mem[0] = 11'h105; mem[1] = 11'h21A; mem[2] = 11'h4F3; mem[3] = 11'h7C0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rstn = 1'b0; start = 1'b0; step = 1'b0; halt_req = 1'b0;
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        log_q.delete();
        tlog_q.delete();
    endtask

    task automatic pulse_start();
        @(negedge clk); start = 1'b1; t0 = cyc;
        @(negedge clk); start = 1'b0;
    endtask

    task automatic pulse_step();
        @(negedge clk); step = 1'b1; t0 = cyc;
        @(negedge clk); step = 1'b0;
    endtask

    task automatic pulse_halt();
        @(negedge clk); halt_req = 1'b1;
        @(negedge clk); halt_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget && !done; i++) @(negedge clk);
        check(tag, 32'(done), 32'd1);
    endtask

    initial begin
        exp_prog[0] = 11'h105; exp_prog[1] = 11'h21A; exp_prog[2] = 11'h4F3; exp_prog[3] = 11'h7C0;
        load_prog();

        // Reset values
        do_reset();
        @(negedge clk);
        check("reset_outs", 32'({imem_addr, imem_rd, issue_valid, opcode, mem_addr, imm_val, busy, done, pc}), 32'd0);

        // Run program
        pulse_start();
        check("run_req_rd", 32'(imem_rd), 32'd1);
        check("run_req_busy", 32'(busy), 32'd1);
        wait_done("run_done", 40);
        check("run_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check($sformatf("run_insn%0d", i), 32'(log_q[i]), 32'(exp_prog[i]));
            check($sformatf("run_time%0d", i), 32'(tlog_q[i] - t0), 32'(3 * (i + 1)));
        end
        check("run_pc", 32'(pc), 32'd3);
        check("run_busy_low", 32'(busy), 32'd0);

        // Backpressure during second ISSUE
        do_reset();
        pulse_start();
        for (int i = 0; i < 20 && !(issue_valid && log_q.size() == 1); i++) @(negedge clk);
        check("bp_second_issue", 32'(issue_valid && log_q.size() == 1), 32'd1);
        issue_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check($sformatf("bp_hold%0d", i), 32'({issue_valid, opcode, mem_addr, imm_val}), 32'({1'b1, 11'h21A}));
        end
        issue_ready = 1'b1;
        wait_done("bp_done", 40);
        check("bp_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++)
            check($sformatf("bp_insn%0d", i), 32'(log_q[i]), 32'(exp_prog[i]));
        if (tlog_q.size() == 4) begin
            check("bp_t1", 32'(tlog_q[1] - t0), 32'd10);
            check("bp_total", 32'(tlog_q[3] - t0), 32'd16);
        end

        // Single-step
        do_reset();
        for (int k = 0; k < 3; k++) begin
            pulse_step();
            if (k == 1) pulse_step();
            repeat (8) @(negedge clk);
            check($sformatf("step%0d_count", k), 32'(log_q.size()), 32'(k + 1));
            if (log_q.size() > k) check($sformatf("step%0d_insn", k), 32'(log_q[k]), 32'(exp_prog[k]));
            check($sformatf("step%0d_pc", k), 32'(pc), 32'(k + 1));
            check($sformatf("step%0d_busy", k), 32'(busy), 32'd0);
        end

        // Halt during first WAIT
        do_reset();
        pulse_start();
        pulse_halt();
        repeat (8) @(negedge clk);
        check("halt_count", 32'(log_q.size()), 32'd1);
        if (log_q.size() > 0) check("halt_insn0", 32'(log_q[0]), 32'h105);
        check("halt_pc", 32'(pc), 32'd1);
        check("halt_idle", 32'({busy, done}), 32'd0);
        pulse_step();
        repeat (8) @(negedge clk);
        check("halt_step_count", 32'(log_q.size()), 32'd2);
        if (log_q.size() > 1) check("halt_step_insn", 32'(log_q[1]), 32'h21A);
        check("halt_step_pc", 32'(pc), 32'd2);

        // Full program space, prog_len = 15
        for (int i = 0; i < 16; i++) mem[i] = {3'(i % 8), 4'(15 - i), 4'(i)};
        prog_len = 4'd15;
        do_reset();
        pulse_start();
        wait_done("full_done", 80);
        check("full_count", 32'(log_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < log_q.size(); i++)
            check($sformatf("full_insn%0d", i), 32'(log_q[i]), 32'({3'(i % 8), 4'(15 - i), 4'(i)}));
        check("full_pc", 32'(pc), 32'd15);

        // start and step together select run mode; step in DONE ignored; start in DONE restarts
        load_prog();
        prog_len = 4'd3;
        do_reset();
        @(negedge clk); start = 1'b1; step = 1'b1;
        @(negedge clk); start = 1'b0; step = 1'b0;
        wait_done("both_done", 40);
        check("both_count", 32'(log_q.size()), 32'd4);
        pulse_step();
        repeat (6) @(negedge clk);
        check("done_step_ignored", 32'({log_q.size() == 4, done, busy}), 32'b110);
        pulse_start();
        check("restart_pc0", 32'(pc), 32'd0);
        check("restart_done_low", 32'(done), 32'd0);
        wait_done("restart_done", 40);
        check("restart_count", 32'(log_q.size()), 32'd8);
        if (log_q.size() > 4) check("restart_insn0", 32'(log_q[4]), 32'h105);
        check("restart_pc", 32'(pc), 32'd3);

        // Asynchronous reset while stalled in ISSUE
        do_reset();
        issue_ready = 1'b0;
        pulse_start();
        for (int i = 0; i < 10 && !issue_valid; i++) @(negedge clk);
        check("rst_pre_valid", 32'(issue_valid), 32'd1);
        #2 rstn = 1'b0;
        #1 check("rst_async_valid", 32'(issue_valid), 32'd0);
        check("rst_async_busy", 32'(busy), 32'd0);
        @(negedge clk);
        rstn = 1'b1;
        issue_ready = 1'b1;
        @(negedge clk);
        check("rst_outs", 32'({imem_addr, imem_rd, issue_valid, opcode, mem_addr, imm_val, busy, done, pc}), 32'd0);
        repeat (4) @(negedge clk);
        check("rst_idle", 32'({imem_rd, busy, done}), 32'd0);
        check("rst_no_issue", 32'(log_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/program_sequencer.md
# program_sequencer

Instruction sequencer for the simple micro-processor. It steps a program counter through a small synchronous instruction memory and fetches each 11-bit instruction word. It then hands the word to the instruction decoder / execution path over a valid/ready issue handshake. It also provides run, single-step and halt control for bring-up and test.

## Interface

Parameters:
- PC_W, 4, program-counter width; program space is 2^PC_W words

Ports:
- clk  in  1  clock; all state changes on rising edge
- rstn  in  1  reset, asynchronous, active-low
- start  in  1  one-cycle pulse; run the program from pc=0
- step  in  1  one-cycle pulse; execute a single instruction at the current pc
- halt_req  in  1  one-cycle pulse; stop after the in-flight instruction is issued
- prog_len  in  PC_W  index of the last instruction; the program is words 0..prog_len
- imem_addr  out  PC_W  instruction memory address
- imem_rd  out  1  instruction memory read strobe
- imem_data  in  11  instruction word, valid the cycle after imem_rd: [10:8] opcode, [7:4] mem_addr, [3:0] imm_val
- issue_valid  out  1  instruction fields valid
- issue_ready  in  1  downstream accepts the instruction
- opcode  out  3  issued opcode
- mem_addr  out  4  issued register address
- imm_val  out  4  issued immediate
- pc  out  PC_W  current program counter
- busy  out  1  high in REQ, WAIT and ISSUE
- done  out  1  high in DONE

## Operation

- States:
  - IDLE
  - REQ: imem_rd=1, imem_addr=pc
  - WAIT: memory returns data; the instruction register loads imem_data at the end of WAIT
  - ISSUE: issue_valid=1; fields come from the instruction register
  - DONE
- Transitions:
  - IDLE
    - start sets pc=0, clears halt_pend and sets mode=RUN, then goes to REQ.
    - Otherwise, step sets mode=STEP and goes to REQ.
  - REQ goes to WAIT unconditionally.
  - WAIT goes to ISSUE unconditionally.
  - ISSUE holds while issue_ready=0. Fields and issue_valid must stay stable while held.
  - ISSUE on transfer (issue_valid && issue_ready):
    - If pc==prog_len: go to DONE; pc holds.
    - Else pc increments by 1. Then:
      - mode=RUN and halt_pend=0: go to REQ.
      - Otherwise: go to IDLE and clear halt_pend.
  - DONE: start behaves exactly as in IDLE. step and halt_req are ignored.
- halt_req while busy sets halt_pend. halt_req in IDLE or DONE is ignored.
- start or step while busy is ignored; neither is queued.
- start and step in the same IDLE cycle: start wins.
- pc arithmetic is modulo 2^PC_W.
  - With prog_len = 2^PC_W−1, the last instruction is at the maximum pc, and DONE is reached without wrapping.
  - Step mode past the maximum pc with prog_len unreachable cannot occur, because pc==prog_len always terminates.
- Opcodes pass through unmodified. The sequencer does not decode them.
- prog_len is sampled only at the ISSUE transfer. Changing it mid-run takes effect at the next comparison.

## Timing

- Reset values: state=IDLE, pc=0, halt_pend=0, mode=RUN, and all outputs 0 (imem_addr=0, imem_rd=0, issue_valid=0, opcode/mem_addr/imm_val=0, busy=0, done=0).
- Asynchronous reset mid-operation: outputs are forced to their reset values immediately. Any in-flight instruction is dropped, with no issue.
- Latency:
  - start/step pulse at edge N puts the block in REQ during cycle N+1.
  - WAIT is cycle N+2.
  - issue_valid is first high in cycle N+3.
- Throughput with issue_ready held high: one instruction per 3 cycles.
- Each cycle of issue_ready=0 in ISSUE adds 1 cycle.
- imem_rd is high for exactly one cycle per instruction.
- done rises the cycle after the final transfer and stays high until start.
- The busy-to-IDLE transition after a halt or step occurs on the transfer edge. busy is low the following cycle.

## Test plan

- Run program: prog_len=3, words 0x105,0x21A,0x4F3,0x7C0, issue_ready=1, pulse start.
  - Issue order is opcode/mem_addr/imm_val 1/0/5, 2/1/A, 4/F/3, 7/C/0.
  - issue_valid first high 3 cycles after start, then every 3 cycles.
  - done=1 with pc=3.
- Backpressure: same program, issue_ready low for 4 cycles during the second ISSUE.
  - Fields stay 2/1/A and stable throughout.
  - Total run is 12+4 cycles.
  - No duplicate or lost instruction.
- Single-step: three step pulses from reset.
  - Exactly one issue per pulse, pc 0→1→2→3.
  - busy returns low between steps.
  - A step pulse while busy produces no extra issue.
- Halt: start, then halt_req during the first WAIT.
  - Instruction 0 is issued, then IDLE with pc=1.
  - A subsequent step issues instruction 1.
- Boundaries:
  - PC_W=4, prog_len=15: 16 issues, done with pc=15.
  - start+step in the same cycle: run mode.
  - start in DONE restarts at pc=0.
- Reset: rstn low during ISSUE with issue_ready=0.
  - issue_valid drops asynchronously.
  - After release, all outputs are 0 and the block is IDLE.
